mem_bus_responder: RTL

Memory-and-I/O responder on the far side of the CPU's byte-wide memory bus: it accepts the address/data/write strobe driven by the CPU's memory interface and returns read bytes one cycle later. It holds the 128 KiB program/data RAM, decodes the I/O window at 0x30000, and buffers UART transmit bytes. It also exposes a cycle counter and a program-stop indication, and drives `io_buffer_full` back to the CPU.

---
 rtl/mem_map_pkg.sv | 36 +++
 rtl/byte_fifo.sv | 56 +++++
 rtl/mem_bus_responder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_map_pkg.sv
// Memory map and bus payload types shared by the memory/I/O responder.
// Holds the I/O window decode constants, the RAM size helper and the
// request struct used to carry one CPU bus transaction.
package mem_map_pkg;

   localparam int unsigned MEM_ADDR_WIDTH = 17;
   localparam int unsigned BUS_DEC_WIDTH  = 18;

   localparam logic [17:0] IO_BASE     = 18'h30000;
   localparam int unsigned IO_UART_OFS = 0;
   localparam int unsigned IO_CLK_OFS  = 4;
   localparam logic [1:0]  IO_SEL      = 2'b11;

   // Byte capacity of a RAM addressed by an aw-bit byte address.
   function automatic int unsigned ram_bytes(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

   localparam int unsigned RAM_BYTES = ram_bytes(MEM_ADDR_WIDTH);

   // One CPU bus transaction, restricted to the decoded address bits.
   typedef struct packed {
      logic [17:0] addr;
      logic [7:0]  wdata;
      logic        wr;
   } bus_req_t;

   // Target selected by the address decoder.
   typedef enum logic [1:0] {
      SEL_RAM  = 2'd0,
      SEL_UART = 2'd1,
      SEL_CLK  = 2'd2,
      SEL_NONE = 2'd3
   } io_sel_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with registered storage.
// Ports: clk/rst_n (async active-low), push/push_data, pop/pop_data,
// full, empty, count (occupancy 0..DEPTH).
// A push while full is accepted only when a pop happens in the same cycle.
module byte_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [7:0]             push_data,
   input  logic                   pop,
   output logic [7:0]             pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [IDX_W:0] wr_ptr;
   logic [IDX_W:0] rd_ptr;
   logic [7:0]     mem_q [DEPTH];
   logic           do_push;
   logic           do_pop;

   // Extra pointer bit separates full (MSBs differ) from empty (equal).
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                     (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
   assign count    = wr_ptr - rd_ptr;
   assign pop_data = mem_q[rd_ptr[IDX_W-1:0]];

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Pointer and storage update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wr_ptr[IDX_W-1:0]] <= push_data;
            wr_ptr                   <= wr_ptr + (IDX_W+1)'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + (IDX_W+1)'(1);
         end
      end
   end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory and I/O responder for the CPU byte-wide memory bus.
// Holds the program/data RAM, the I/O window at 0x30000 (UART TX/RX,
// cycle counter, program stop) and the UART transmit FIFO.
// Ports:
//   clk_in, rst_n_in (async active-low), rdy_in (global enable)
//   mem_a/mem_dout/mem_wr : CPU request; mem_din : read data, 1 cycle later
//   io_buffer_full        : TX FIFO almost full (occupancy >= TX_DEPTH-2)
//   tx_data/tx_valid/tx_ready : UART transmit handshake
//   rx_data/rx_valid/rx_pop   : UART receive, rx_pop combinational
//   program_stop          : sticky, set by a write to 0x30004
// Build option: define MEM_RESP_CYCLE_COUNTER_EN to implement the cycle
// counter and its read snapshot; otherwise 0x30004-0x30007 read as 0x00.
module mem_bus_responder
   import mem_map_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
   parameter int unsigned TX_DEPTH   = 8
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_pop,
   output logic        program_stop
);

   localparam int unsigned RAM_DEPTH = ram_bytes(ADDR_WIDTH);
   localparam int unsigned CNT_W     = $clog2(TX_DEPTH) + 1;
   localparam logic [17:0] UART_ADDR = IO_BASE + 18'(IO_UART_OFS);
   localparam logic [17:0] CLK_ADDR  = IO_BASE + 18'(IO_CLK_OFS);

   bus_req_t              req;
   io_sel_e               sel;
   logic                  rd_en;
   logic                  wr_en;
   logic                  stop_wr;
   logic [ADDR_WIDTH-1:0] ram_idx;
   logic [7:0]            ram [RAM_DEPTH];
   logic [7:0]            rdata;
   logic [7:0]            clk_byte;
   logic                  tx_push;
   logic [7:0]            tx_push_data;
   logic                  tx_pop;
   logic                  tx_full;
   logic                  tx_empty;
   logic [CNT_W-1:0]      tx_count;
   logic                  unused_addr_hi;

   // Only bits 17:0 of the CPU address take part in decode.
   assign unused_addr_hi = ^mem_a[31:18];

   assign req     = '{addr: mem_a[17:0], wdata: mem_dout, wr: mem_wr};
   assign rd_en   = rdy_in & ~req.wr;
   assign wr_en   = rdy_in &  req.wr;
   assign ram_idx = req.addr[ADDR_WIDTH-1:0];

   // Address decode: top two bits pick the I/O window, then exact offsets.
   always_comb begin
      sel = SEL_RAM;
      if (req.addr[17:16] == IO_SEL) begin
         if (req.addr == UART_ADDR) begin
            sel = SEL_UART;
         end else if (req.addr[17:2] == CLK_ADDR[17:2]) begin
            sel = SEL_CLK;
         end else begin
            sel = SEL_NONE;
         end
      end
   end

   assign stop_wr = wr_en & (req.addr == CLK_ADDR);

   // RAM byte write; contents are deliberately not reset.
   always_ff @(posedge clk_in) begin
      if (wr_en && (sel == SEL_RAM)) begin
         ram[ram_idx] <= req.wdata;
      end
   end

`ifdef MEM_RESP_CYCLE_COUNTER_EN
   logic [31:0] cycle_cnt;
   logic [31:0] snap_q;

   // Free-running cycle counter; a read of byte 0 latches the snapshot
   // so the following byte 1..3 reads form one coherent 32-bit value.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cycle_cnt <= '0;
         snap_q    <= '0;
      end else if (rdy_in) begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (rd_en && (sel == SEL_CLK) && (req.addr[1:0] == 2'b00)) begin
            snap_q <= cycle_cnt;
         end
      end
   end

   // Byte 0 comes from the live count, bytes 1..3 from the snapshot.
   always_comb begin
      clk_byte = snap_q[{req.addr[1:0], 3'b000} +: 8];
      if (req.addr[1:0] == 2'b00) begin
         clk_byte = cycle_cnt[7:0];
      end
   end
`else
   assign clk_byte = 8'h00;
`endif

   // Read data select for the registered return path.
   always_comb begin
      rdata = 8'h00;
      case (sel)
         SEL_RAM:  rdata = ram[ram_idx];
         SEL_UART: if (rx_valid) rdata = rx_data;
         SEL_CLK:  rdata = clk_byte;
         default:  rdata = 8'h00;
      endcase
   end

   // Registered read data; held across write and stalled cycles.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         mem_din <= 8'h00;
      end else if (rd_en) begin
         mem_din <= rdata;
      end
   end

   // Sticky stop flag.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         program_stop <= 1'b0;
      end else if (stop_wr) begin
         program_stop <= 1'b1;
      end
   end

   // RX consume strobe, forced low while reset is asserted.
   assign rx_pop = rst_n_in & rd_en & (sel == SEL_UART) & rx_valid;

   // TX push: nonzero UART bytes, plus the 0x00 marker from a stop write.
   assign tx_push      = (wr_en & (sel == SEL_UART) & (|req.wdata)) | stop_wr;
   assign tx_push_data = stop_wr ? 8'h00 : req.wdata;

   // UART side keeps draining even when the bus is stalled.
   assign tx_pop = tx_valid & tx_ready;

   byte_fifo #(
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk       (clk_in),
      .rst_n     (rst_n_in),
      .push      (tx_push),
      .push_data (tx_push_data),
      .pop       (tx_pop),
      .pop_data  (tx_data),
      .full      (tx_full),
      .empty     (tx_empty),
      .count     (tx_count)
   );

   assign tx_valid = ~tx_empty;

   // Two entries of headroom because the CPU samples this late.
   assign io_buffer_full = (tx_count >= CNT_W'(TX_DEPTH - 2));

   logic unused_tx_full;
   assign unused_tx_full = tx_full;

endmodule
